// File: rtl/program_sequencer_pkg.sv
// Shared ISA definitions for the program sequencer and its return stack.
package program_sequencer_pkg;

  localparam int unsigned PC_W        = 12;
  localparam int unsigned INSTR_W     = 16;
  localparam int unsigned STACK_DEPTH = 4;
  localparam int unsigned SP_W        = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W       = $clog2(STACK_DEPTH);

  // Control opcodes; every other opcode value is an array instruction.
  localparam logic [3:0] OP_JUMP    = 4'h1;
  localparam logic [3:0] OP_CALL    = 4'h2;
  localparam logic [3:0] OP_RET     = 4'h3;
  localparam logic [3:0] OP_LOOP    = 4'h4;
  localparam logic [3:0] OP_ENDLOOP = 4'h5;
  localparam logic [3:0] OP_SYNC    = 4'h6;
  localparam logic [3:0] OP_HALT    = 4'h7;

  // Sequential successor of an instruction address, modulo 2**PC_W.
  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + PC_W'(2);
  endfunction

  // Control-transfer targets are always halfword aligned.
  function automatic logic [PC_W-1:0] jump_target(input logic [PC_W-1:0] operand);
    return {operand[PC_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/program_sequencer_return_stack.sv
// Fixed-depth LIFO of return addresses with full/empty status.
module return_stack
  import program_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] data_in,
  output logic [PC_W-1:0] data_out,
  output logic            full,
  output logic            empty
);

  logic [PC_W-1:0] mem_q [STACK_DEPTH];
  logic [PC_W-1:0] mem_d [STACK_DEPTH];
  logic [SP_W-1:0] sp_q;
  logic [SP_W-1:0] sp_d;

  assign full     = (sp_q == SP_W'(STACK_DEPTH));
  assign empty    = (sp_q == '0);
  assign data_out = empty ? '0 : mem_q[IDX_W'(sp_q - SP_W'(1))];

  // Next stack contents and pointer; clear wins, overflow/underflow are no-ops.
  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    if (clear) begin
      sp_d = '0;
    end else if (push && !full) begin
      mem_d[IDX_W'(sp_q)] = data_in;
      sp_d                = sp_q + SP_W'(1);
    end else if (pop && !empty) begin
      sp_d = sp_q - SP_W'(1);
    end
  end

  // Stack storage and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      mem_q <= '{default: '0};
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Instruction sequencer: fetches 16-bit words, executes control flow locally
// and hands every other instruction to the cell array.
module program_sequencer
  import program_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               issue_valid,
  output logic [INSTR_W-1:0] issue_instr,
  input  logic               issue_ready,
  input  logic               array_busy,
  output logic               busy,
  output logic               halted,
  output logic               fault
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    SYNC_WAIT,
    HALTED
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    loop_cnt_q, loop_cnt_d;
  logic [PC_W-1:0]    loop_start_q, loop_start_d;
  logic               fault_q, fault_d;

  logic               stk_clear, stk_push, stk_pop;
  logic               stk_full, stk_empty;
  logic [PC_W-1:0]    stk_top;

  logic [3:0]         opcode;
  logic [PC_W-1:0]    operand;
  logic [PC_W-1:0]    pc_plus2;
  logic [PC_W-1:0]    jump_tgt;

  assign opcode   = instr_q[INSTR_W-1 -: 4];
  assign operand  = instr_q[PC_W-1:0];
  assign pc_plus2 = pc_next(pc_q);
  assign jump_tgt = jump_target(operand);

  assign imem_addr = pc_q;
  assign busy      = (state_q != IDLE) && (state_q != HALTED);
  assign halted    = (state_q == HALTED);
  assign fault     = fault_q;

  return_stack u_return_stack (
    .clk      (clk),
    .rst      (rst),
    .clear    (stk_clear),
    .push     (stk_push),
    .pop      (stk_pop),
    .data_in  (pc_plus2),
    .data_out (stk_top),
    .full     (stk_full),
    .empty    (stk_empty)
  );

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    loop_cnt_d   = loop_cnt_q;
    loop_start_d = loop_start_q;
    fault_d      = fault_q;
    stk_clear    = 1'b0;
    stk_push     = 1'b0;
    stk_pop      = 1'b0;
    imem_req     = 1'b0;
    issue_valid  = 1'b0;
    issue_instr  = '0;

    unique case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          state_d      = FETCH;
          pc_d         = '0;
          loop_cnt_d   = '0;
          loop_start_d = '0;
          fault_d      = 1'b0;
          stk_clear    = 1'b1;
        end
      end

      FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          instr_d = imem_data;
          state_d = EXEC;
        end
      end

      EXEC: begin
        state_d = FETCH;
        case (opcode)
          OP_JUMP: pc_d = jump_tgt;
          OP_CALL: begin
            if (stk_full) begin
              fault_d = 1'b1;
              state_d = HALTED;
            end else begin
              stk_push = 1'b1;
              pc_d     = jump_tgt;
            end
          end
          OP_RET: begin
            if (stk_empty) begin
              fault_d = 1'b1;
              state_d = HALTED;
            end else begin
              stk_pop = 1'b1;
              pc_d    = stk_top;
            end
          end
          OP_LOOP: begin
            loop_cnt_d   = (operand == '0) ? PC_W'(1) : operand;
            loop_start_d = pc_plus2;
            pc_d         = pc_plus2;
          end
          OP_ENDLOOP: begin
            if (loop_cnt_q == '0) begin
              fault_d = 1'b1;
              state_d = HALTED;
            end else if (loop_cnt_q > PC_W'(1)) begin
              loop_cnt_d = loop_cnt_q - PC_W'(1);
              pc_d       = loop_start_q;
            end else begin
              loop_cnt_d = '0;
              pc_d       = pc_plus2;
            end
          end
          OP_SYNC: begin
            pc_d    = pc_plus2;
            state_d = SYNC_WAIT;
          end
          OP_HALT: state_d = HALTED;
          default: begin
            issue_valid = 1'b1;
            issue_instr = instr_q;
            if (issue_ready) begin
              pc_d = pc_plus2;
            end else begin
              state_d = EXEC;
            end
          end
        endcase
      end

      SYNC_WAIT: begin
        if (!array_busy) begin
          state_d = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      instr_q      <= '0;
      loop_cnt_q   <= '0;
      loop_start_q <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      loop_cnt_q   <= loop_cnt_d;
      loop_start_q <= loop_start_d;
      fault_q      <= fault_d;
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench: directed scenarios plus random programs compared
// against an instruction-level interpreter.
module tb_program_sequencer;
  import program_sequencer_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_data;
  logic               issue_valid;
  logic [INSTR_W-1:0] issue_instr;
  logic               issue_ready;
  logic               array_busy;
  logic               busy;
  logic               halted;
  logic               fault;

  program_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_data   (imem_data),
    .issue_valid (issue_valid),
    .issue_instr (issue_instr),
    .issue_ready (issue_ready),
    .array_busy  (array_busy),
    .busy        (busy),
    .halted      (halted),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [2048];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  int unsigned exp_fetch[$];
  int unsigned exp_issue[$];
  int unsigned exp_pc;
  int unsigned exp_fault;
  int unsigned got_fetch[$];
  int unsigned got_issue[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input int unsigned opnd);
    logic [11:0] o;
    o = 12'(opnd);
    return {op, o};
  endfunction

  function automatic logic [15:0] rand_op();
    int unsigned r;
    logic [3:0] opc;
    r   = $urandom_range(0, 8);
    opc = (r == 0) ? 4'h0 : 4'(r + 7);
    return mk(opc, $urandom);
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) mem[i] = mk(OP_HALT, 0);
  endtask

  // Instruction-level interpreter of the ISA over mem[].
  task automatic model_run();
    int unsigned pc, lc, ls, opnd;
    int unsigned stk[$];
    logic [15:0] w;
    logic [3:0]  op;
    bit done;
    exp_fetch.delete(); exp_issue.delete();
    pc = 0; lc = 0; ls = 0; exp_fault = 0; done = 0;
    for (int step = 0; step < 4000 && !done; step++) begin
      exp_fetch.push_back(pc);
      w    = mem[pc / 2];
      op   = w[15:12];
      opnd = int'(w[11:0]);
      case (op)
        OP_JUMP: pc = opnd & 32'hFFE;
        OP_CALL: begin
          if (stk.size() == 4) begin exp_fault = 1; done = 1; end
          else begin stk.push_back((pc + 2) % 4096); pc = opnd & 32'hFFE; end
        end
        OP_RET: begin
          if (stk.size() == 0) begin exp_fault = 1; done = 1; end
          else pc = stk.pop_back();
        end
        OP_LOOP: begin
          lc = (opnd == 0) ? 1 : opnd;
          ls = (pc + 2) % 4096;
          pc = (pc + 2) % 4096;
        end
        OP_ENDLOOP: begin
          if (lc == 0) begin exp_fault = 1; done = 1; end
          else if (lc > 1) begin lc = lc - 1; pc = ls; end
          else begin lc = 0; pc = (pc + 2) % 4096; end
        end
        OP_SYNC: pc = (pc + 2) % 4096;
        OP_HALT: done = 1;
        default: begin
          exp_issue.push_back(int'(w));
          pc = (pc + 2) % 4096;
        end
      endcase
    end
    exp_pc = pc;
  endtask

  // Start the DUT and serve memory/array handshakes until it halts.
  task automatic run_dut(input bit easy, input int unsigned budget);
    bit done;
    got_fetch.delete(); got_issue.delete();
    done = 0;
    @(negedge clk);
    start = 1'b1; imem_valid = 1'b0; issue_ready = 1'b0; array_busy = 1'b0;
    for (int unsigned c = 0; c < budget; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("fault_cleared_on_start", 32'(fault), 0);
        check("busy_after_start", 32'(busy), 1);
      end
      if (halted) begin done = 1; break; end
      start       = busy && !easy && ($urandom_range(0, 7) == 0);
      imem_valid  = easy ? 1'b1 : ($urandom_range(0, 9) < 6);
      imem_data   = imem_req ? mem[imem_addr[11:1]] : 16'($urandom);
      if (imem_req && imem_valid) got_fetch.push_back(int'(imem_addr));
      issue_ready = easy ? 1'b1 : ($urandom_range(0, 9) < 6);
      if (issue_valid && issue_ready) got_issue.push_back(int'(issue_instr));
      array_busy  = easy ? 1'b0 : 1'($urandom_range(0, 1));
    end
    start = 1'b0; imem_valid = 1'b0; issue_ready = 1'b0; array_busy = 1'b0;
    check("run_reached_halt", 32'(done), 1);
  endtask

  task automatic compare_run(input string tag);
    int n;
    model_run();
    check({tag, "_fetch_count"}, got_fetch.size(), exp_fetch.size());
    n = (got_fetch.size() < exp_fetch.size()) ? got_fetch.size() : exp_fetch.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_fetch[%0d]", tag, i), got_fetch[i], exp_fetch[i]);
    check({tag, "_issue_count"}, got_issue.size(), exp_issue.size());
    n = (got_issue.size() < exp_issue.size()) ? got_issue.size() : exp_issue.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_issue[%0d]", tag, i), got_issue[i], exp_issue[i]);
    check({tag, "_halted"}, 32'(halted), 1);
    check({tag, "_fault"}, 32'(fault), exp_fault);
    check({tag, "_pc"}, 32'(imem_addr), exp_pc);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check({tag, "_imem_req"}, 32'(imem_req), 0);
    check({tag, "_issue_valid"}, 32'(issue_valid), 0);
    check({tag, "_issue_instr"}, 32'(issue_instr), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_halted"}, 32'(halted), 0);
    check({tag, "_fault"}, 32'(fault), 0);
    check({tag, "_pc"}, 32'(imem_addr), 0);
    rst = 1'b0;
  endtask

  task automatic gen_program();
    int unsigned a, nblk, kind;
    clear_mem();
    mem[12'h200] = rand_op();
    mem[12'h201] = mk(OP_RET, 0);
    a    = 0;
    nblk = $urandom_range(3, 8);
    for (int unsigned b = 0; b < nblk; b++) begin
      kind = $urandom_range(0, 11);
      if (kind <= 3) begin
        mem[a] = rand_op(); a += 1;
      end else if (kind == 4) begin
        mem[a] = mk(OP_SYNC, 0); a += 1;
      end else if (kind <= 6) begin
        mem[a]     = mk(OP_LOOP, $urandom_range(0, 3));
        mem[a + 1] = rand_op();
        mem[a + 2] = mk(OP_ENDLOOP, 0);
        a += 3;
      end else if (kind == 7) begin
        mem[a]     = mk(OP_JUMP, (a + 2) * 2 + $urandom_range(0, 1));
        mem[a + 1] = rand_op();
        a += 2;
      end else if (kind <= 9) begin
        mem[a] = mk(OP_CALL, 12'h400 + $urandom_range(0, 1)); a += 1;
      end else if (kind == 10) begin
        mem[a] = ($urandom_range(0, 3) == 0) ? mk(OP_RET, 0) : rand_op(); a += 1;
      end else begin
        mem[a] = ($urandom_range(0, 3) == 0) ? mk(OP_ENDLOOP, 0) : rand_op(); a += 1;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; imem_valid = 1'b0; imem_data = '0;
    issue_ready = 1'b0; array_busy = 1'b0;
    repeat (2) @(negedge clk);
    do_reset("reset");

    // Jump then halt.
    clear_mem();
    mem[0] = mk(OP_JUMP, 12'h010);
    run_dut(1'b0, 2000);
    compare_run("jump");
    check("jump_nfetch", got_fetch.size(), 2);
    if (got_fetch.size() >= 2) begin
      check("jump_fetch0", got_fetch[0], 12'h000);
      check("jump_fetch1", got_fetch[1], 12'h010);
    end
    check("jump_pc", 32'(imem_addr), 12'h010);

    // Three-iteration loop around one array op.
    clear_mem();
    mem[0] = mk(OP_LOOP, 3);
    mem[1] = 16'h8ABC;
    mem[2] = mk(OP_ENDLOOP, 0);
    run_dut(1'b1, 2000);
    compare_run("loop3");
    check("loop3_handshakes", got_issue.size(), 3);

    // Fifth nested call overflows the stack.
    clear_mem();
    mem[12'h000] = mk(OP_CALL, 12'h100);
    mem[12'h080] = mk(OP_CALL, 12'h200);
    mem[12'h100] = mk(OP_CALL, 12'h300);
    mem[12'h180] = mk(OP_CALL, 12'h400);
    mem[12'h200] = mk(OP_CALL, 12'h500);
    run_dut(1'b0, 2000);
    compare_run("call5");
    check("call5_fault", 32'(fault), 1);
    check("call5_pc", 32'(imem_addr), 12'h400);

    // Array op at the top of the address space wraps to 0.
    clear_mem();
    mem[0]      = mk(OP_CALL, 12'hFFF);
    mem[12'h7FF] = 16'h9555;
    run_dut(1'b0, 3000);
    compare_run("wrap");
    if (got_fetch.size() >= 3) begin
      check("wrap_fetch1", got_fetch[1], 12'hFFE);
      check("wrap_fetch2", got_fetch[2], 12'h000);
    end

    // SYNC held off by array_busy for 7 cycles.
    clear_mem();
    mem[0] = mk(OP_SYNC, 0);
    @(negedge clk);
    start = 1'b1; array_busy = 1'b1; imem_valid = 1'b1; imem_data = 16'($urandom);
    @(negedge clk);
    start = 1'b0;
    check("sync_fetch_req", 32'(imem_req), 1);
    check("sync_fetch_addr", 32'(imem_addr), 0);
    imem_data = mem[0];
    @(negedge clk);
    imem_data = 16'($urandom);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check($sformatf("sync_quiet[%0d]", i), 32'(imem_req), 0);
      imem_data = 16'($urandom);
    end
    array_busy = 1'b0;
    @(negedge clk);
    check("sync_refetch_req", 32'(imem_req), 1);
    check("sync_refetch_addr", 32'(imem_addr), 2);
    imem_data = mem[1];
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    check("sync_halted", 32'(halted), 1);

    // Stalled issue interrupted by reset.
    clear_mem();
    mem[0] = 16'h8123;
    @(negedge clk);
    start = 1'b1; imem_valid = 1'b1; issue_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; imem_data = mem[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      imem_data = 16'($urandom);
      check($sformatf("stall_valid[%0d]", i), 32'(issue_valid), 1);
      check($sformatf("stall_instr[%0d]", i), 32'(issue_instr), 32'h8123);
      check($sformatf("stall_pc[%0d]", i), 32'(imem_addr), 0);
    end
    @(negedge clk);
    check("stall_pc_before_rst", 32'(imem_addr), 0);
    rst = 1'b1; issue_ready = 1'b1;
    @(negedge clk);
    check("stall_rst_valid", 32'(issue_valid), 0);
    check("stall_rst_instr", 32'(issue_instr), 0);
    check("stall_rst_idle", 32'({busy, halted}), 0);
    check("stall_rst_pc", 32'(imem_addr), 0);
    rst = 1'b0; issue_ready = 1'b0; imem_valid = 1'b0;

    // Random programs.
    for (int t = 0; t < 25; t++) begin
      gen_program();
      run_dut(1'b0, 3000);
      compare_run($sformatf("rand%0d", t));
      if ((t % 6) == 5) do_reset($sformatf("rand_reset%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
